// File: rtl/dm_reader.sv
// dm_reader: two-stage load formatter for the data RAM read port.
// S1 carries the load shape; a 2-deep FIFO returns results in order.
module dm_reader (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  output logic        ram_en,
  output logic [12:0] ram_addr,
  input  logic [31:0] ram_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam logic [2:0] T_LW  = 3'd0;
  localparam logic [2:0] T_LH  = 3'd1;
  localparam logic [2:0] T_LHU = 3'd2;
  localparam logic [2:0] T_LB  = 3'd3;
  localparam logic [2:0] T_LBU = 3'd4;

  logic        s1_valid;
  logic [1:0]  s1_off;
  logic [2:0]  s1_type;

  logic [31:0] fifo_data [2];
  logic        fifo_err  [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;

  logic        accept;
  logic        push;
  logic        pop;
  logic [2:0]  occ;

  logic [15:0] half;
  logic [7:0]  bsel;
  logic [31:0] fmt_data;
  logic        fmt_err;

  logic        unused_addr;

  assign unused_addr = ^req_addr[31:15];

  // Occupancy seen by the next accept: S1 + FIFO, less what leaves now.
  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = s1_valid;
  assign occ       = {2'b00, s1_valid} + {1'b0, count} - {2'b00, pop};
  assign req_ready = (occ < 3'd2);
  assign accept    = req_valid & req_ready & clr_n;
  assign ram_en    = accept;
  assign ram_addr  = req_addr[14:2];

  assign rsp_data  = rsp_valid ? fifo_data[rptr] : 32'd0;
  assign rsp_err   = rsp_valid & fifo_err[rptr];

  // Lane select and extension of the RAM word for the S1 load.
  always_comb begin
    fmt_data = 32'd0;
    fmt_err  = 1'b0;
    half     = s1_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (s1_off)
      2'd0:    bsel = ram_rdata[7:0];
      2'd1:    bsel = ram_rdata[15:8];
      2'd2:    bsel = ram_rdata[23:16];
      default: bsel = ram_rdata[31:24];
    endcase
    case (s1_type)
      T_LW: begin
        if (s1_off != 2'd0) fmt_err = 1'b1;
        else fmt_data = ram_rdata;
      end
      T_LH: begin
        if (s1_off[0]) fmt_err = 1'b1;
        else fmt_data = {{16{half[15]}}, half};
      end
      T_LHU: begin
        if (s1_off[0]) fmt_err = 1'b1;
        else fmt_data = {16'd0, half};
      end
      T_LB:    fmt_data = {{24{bsel[7]}}, bsel};
      T_LBU:   fmt_data = {24'd0, bsel};
      default: fmt_err = 1'b1;
    endcase
  end

  // S1 holds the shape of the load whose RAM read is in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_valid <= 1'b0;
      s1_off   <= 2'd0;
      s1_type  <= 3'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_off  <= req_addr[1:0];
        s1_type <= req_type;
      end
    end
  end

  // Two-entry response FIFO; credit check upstream prevents overflow.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= 32'd0;
      fifo_data[1] <= 32'd0;
      fifo_err[0]  <= 1'b0;
      fifo_err[1]  <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wptr] <= fmt_data;
        fifo_err[wptr]  <= fmt_err;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/dm_reader.md
DM_READER -- requirements
Module: dm_reader

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 clr_n  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  load request present.
REQ-004 req_ready  out  1  request accepted this cycle when req_valid & req_ready.
REQ-005 req_addr  in  32  byte address of load.
REQ-006 req_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 illegal.
REQ-007 ram_en  out  1  read strobe to data RAM; equals req_valid & req_ready.
REQ-008 ram_addr  out  13  word index to data RAM; equals req_addr[14:2], combinational.
REQ-009 ram_rdata  in  32  RAM read word; valid exactly one cycle after the ram_en edge.
REQ-010 rsp_valid  out  1  response present at FIFO head.
REQ-011 rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready.
REQ-012 rsp_data  out  32  formatted load result.
REQ-013 rsp_err  out  1  request was misaligned or had an illegal type.

Function
REQ-014 Stage S1 SHALL hold s1_valid, offset = req_addr[1:0] and req_type for the accepted request; it is loaded on each accept and cleared when no accept occurs.
REQ-015 The cycle after an accept, the S1 entry and ram_rdata SHALL be formatted and pushed into a 2-entry output FIFO at the next edge.
REQ-016 Byte lanes are little-endian: byte k = ram_rdata[8k+7:8k], selected by offset k.
REQ-017 LW SHALL return ram_rdata unchanged.
REQ-018 LH/LHU SHALL select ram_rdata[15:0] for offset 0 and [31:16] for offset 2; LH sign-extends bit 15 of the half, LHU zero-extends.
REQ-019 LB/LBU SHALL select byte at offset; LB sign-extends bit 7 of the byte, LBU zero-extends.
REQ-020 Error cases: LW with offset != 0, LH/LHU with offset[0] = 1, illegal type. Each SHALL produce a FIFO entry with rsp_err = 1 and rsp_data = 0. The RAM read still issues and its result is discarded.
REQ-021 Latency: a request accepted at edge t SHALL present rsp_valid after edge t+1 (2 cycles from accept to response visible), if the FIFO has room.
REQ-022 Credit rule: req_ready = (s1_valid + fifo_count - (rsp_valid & rsp_ready)) < 2. This SHALL guarantee that a FIFO push never overflows.
REQ-023 With rsp_ready held high, the block SHALL sustain one accepted request per cycle.
REQ-024 Simultaneous push and pop SHALL keep fifo_count unchanged and preserve order. Pop from an empty FIFO SHALL have no effect.
REQ-025 Responses SHALL be returned strictly in request order.
REQ-026 When rsp_valid = 0, rsp_data and rsp_err SHALL be 0.
REQ-027 Ordering of loads against concurrent stores to the same word is the caller's responsibility. This block reads ram_rdata as presented.

Reset
REQ-028 clr_n low SHALL immediately clear s1_valid, fifo_count and the FIFO read/write pointers. It SHALL also force rsp_valid = 0, rsp_data = 0, rsp_err = 0 and req_ready = 1.
REQ-029 Reset asserted mid-operation SHALL discard in-flight and buffered requests. No response for them appears after clr_n returns high.
REQ-030 ram_en SHALL be 0 while clr_n is low, regardless of req_valid.

Verification
REQ-031 Stream test: RAM word 0x8081_7F01 at index 5. LB @0x14, LBU @0x15, LB @0x17 and LBU @0x17 are issued back-to-back with rsp_ready = 1. Expected responses, in order on consecutive cycles: 0x0000_0001, 0x0000_007F, 0xFFFF_FF80, 0x0000_0080.
REQ-032 Half test: same word. LH @0x16 -> 0xFFFF_8081. LHU @0x16 -> 0x0000_8081. LH @0x14 -> 0x0000_7F01. LW @0x14 -> 0x8081_7F01.
REQ-033 Error test: LW @0x16, LH @0x15 and type 111 @0x14 each -> rsp_err = 1, rsp_data = 0. A following LW @0x14 -> rsp_err = 0, correct data.
REQ-034 Backpressure test: rsp_ready = 0, req_valid held high. Exactly 2 accepts occur, then req_ready = 0. Releasing rsp_ready drains both in order and resumes one accept per cycle.
REQ-035 Reset test: assert clr_n low while S1 and FIFO hold entries. Outputs go to their reset values asynchronously. After release, no stale response appears.
REQ-036 Check ram_addr = req_addr[14:2] and ram_en = req_valid & req_ready on every cycle.
